memory_model_dp: RTL and testbench
==================================

Name: memory_model_dp

Overview:
- Parametrised successor to the single-port soft memory model: one read/write port (A) and one read-only port (B) on a shared array.
- Adds byte-enable writes, configurable read latency with valid tagging, req/gnt handshake, out-of-range error reporting, and a post-reset scrub FSM.
- Used as the SoC data/instruction RAM model where the core's fetch unit (B) and LSU (A) share one memory.

Parameters:
- WORD_SIZE_BYTE, 4, bytes per word; byte-enable width.
- SIZE_IN_KB, 8, capacity; DEPTH = SIZE_IN_KB*1024/WORD_SIZE_BYTE.
- READ_LATENCY, 1, cycles from accepted read to rvalid; legal 1..3.
- WRITE_MODE, 0, A-write/B-read collision: 0 = read-first (old data), 1 = write-first (new data).
- SCRUB_ON_RESET, 1, 1 = fill array with INIT_VALUE after reset; 0 = skip.
- INIT_VALUE, 0, scrub word value (WORD_SIZE_BYTE*8 bits).
- Derived localparams: DW = WORD_SIZE_BYTE*8; AW = $clog2(DEPTH)+1 (MSB reserved for range check).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- init_done_o  out  1  high once the array is usable.
- a_req_i  in  1  port A request.
- a_we_i  in  WORD_SIZE_BYTE  byte write enables; all-zero = read.
- a_addr_i  in  AW  word address.
- a_wdata_i  in  DW  write data.
- a_gnt_o  out  1  request accepted this cycle.
- a_rvalid_o  out  1  read data valid.
- a_rdata_o  out  DW  read data.
- a_err_o  out  1  qualifies a_rvalid_o; access was out of range.
- b_req_i  in  1  port B read request.
- b_addr_i  in  AW  word address.
- b_gnt_o  out  1  request accepted.
- b_rvalid_o  out  1  read data valid.
- b_rdata_o  out  DW  read data.
- b_err_o  out  1  qualifies b_rvalid_o; out of range.

Behaviour:
- Reset: all outputs 0; FSM -> SCRUB (if SCRUB_ON_RESET) else READY; scrub counter 0; valid pipelines flushed. Array contents are not reset.
- FSM SCRUB:
  - Writes INIT_VALUE to address cnt each cycle, cnt 0..DEPTH-1.
  - After writing DEPTH-1 -> READY.
  - gnt outputs held 0; requests ignored, not queued.
- FSM READY:
  - init_done_o = 1, registered; it rises the cycle after the last scrub write.
  - a_gnt_o = a_req_i, b_gnt_o = b_req_i (combinational, no backpressure in READY).
- Reset mid-scrub: scrub restarts at address 0 and init_done_o drops immediately.
- Accepted write (req & gnt & |we):
  - Each lane i with we[i]=1 updated; other lanes keep their value.
  - No rvalid is generated.
- Accepted read: rdata/rvalid/err appear exactly READY_LATENCY... precisely READ_LATENCY cycles later.
  - Pipelined: one read per port per cycle, back-to-back allowed.
  - rdata holds its value until the next rvalid.
- Out of range (addr >= DEPTH):
  - Write suppressed.
  - Read returns rvalid=1, err=1, rdata=0.
  - Writes out of range produce no response.
- Collision (A write and B read, same address, same cycle):
  - WRITE_MODE=0: B returns the pre-write word.
  - WRITE_MODE=1: B returns the merged word (new lanes where we=1, old elsewhere).
- A read and B read to the same address: both return the same data, no conflict.
- Latency pipeline: valid/err/data shift registers of depth READ_LATENCY per port; stage 1 is the array read register.
- Illegal READ_LATENCY: rejected by an elaboration-time $error.
- Assertions:
  - No gnt while init_done_o = 0.
  - a_err_o/b_err_o only asserted together with the matching rvalid.

Decomposition:
- Package mem_model_pkg:
  - scrub FSM state enum (SCRUB, READY).
  - Helper functions for depth and address width.
  - Collision mode constants READ_FIRST = 0, WRITE_FIRST = 1.
- Sub-module mem_rd_pipe: parametrised READ_LATENCY valid/err/data delay line, instantiated once per port.
- Array and FSM stay in the top module.

Test Plan:
1. Scrub completion (SIZE_IN_KB=1, WORD=4, DEPTH=256): deassert rst_i -> init_done_o rises exactly 256 cycles after reset release. B reads of address 0 and 255 then return 0x00000000.
2. Reset mid-scrub: assert rst_i at scrub cycle 100, release -> init_done_o = 0 immediately. Rises 256 cycles after the second release; no gnt seen before that.
3. Byte-lane write: A writes 0xAABBCCDD to address 5 with we=1111, then 0x11223344 with we=0101 -> read of address 5 returns 0xAA22CC44 with READ_LATENCY=2 (rvalid two cycles after gnt).
4. Collision: address 7 holds 0x0; same cycle A writes 0xFFFFFFFF (we=1111) and B reads address 7 -> WRITE_MODE=0 returns 0x0; WRITE_MODE=1 returns 0xFFFFFFFF.
5. Out of range: A reads address 256 (DEPTH=256) -> rvalid=1, err=1, rdata=0. A writes address 300 -> no array change; address 44 (300 mod 256) is unchanged.
6. Streaming: B issues reads of addresses 0..15 on consecutive cycles with READ_LATENCY=3 -> 16 consecutive rvalid cycles, in order, first one 3 cycles after the first gnt.

Source files
------------

// File: rtl/mem_model_pkg.sv
// Shared types and sizing helpers for the dual-port memory model.
package mem_model_pkg;

   typedef enum logic {SCRUB, READY} scrub_state_e;

   localparam int READ_FIRST  = 0;
   localparam int WRITE_FIRST = 1;

   function automatic int mem_depth(input int size_kb, input int word_bytes);
      return size_kb * 1024 / word_bytes;
   endfunction

   // One extra MSB so addresses at or beyond DEPTH can be recognised as out of range.
   function automatic int mem_addr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: valid/err/data delayed LATENCY cycles; stage 0 registers the array read.
// No backpressure; data holds its last value until the next valid response.
module mem_rd_pipe #(
   parameter int LATENCY = 1,
   parameter int DW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_vld,
   input  logic          in_err,
   input  logic [DW-1:0] in_dat,
   output logic          out_vld,
   output logic          out_err,
   output logic [DW-1:0] out_dat
);

   logic [LATENCY-1:0] vld_q;
   logic [LATENCY-1:0] err_q;
   logic [DW-1:0]      dat_q [LATENCY];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         err_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= in_vld;
         err_q[0] <= in_vld & in_err;
         if (in_vld) begin
            dat_q[0] <= in_dat;
         end
         for (int k = 1; k < LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            err_q[k] <= err_q[k-1];
            if (vld_q[k-1]) begin
               dat_q[k] <= dat_q[k-1];
            end
         end
      end
   end

   assign out_vld = vld_q[LATENCY-1];
   assign out_err = err_q[LATENCY-1];
   assign out_dat = dat_q[LATENCY-1];

endmodule

// File: rtl/memory_model_dp.sv
// Dual-port RAM model (A read/write with byte enables, B read-only), READ_LATENCY-cycle reads, post-reset scrub.
// No backpressure once ready; requests during scrub are not granted and are dropped.
module memory_model_dp
   import mem_model_pkg::*;
#(
   parameter int                          WORD_SIZE_BYTE = 4,
   parameter int                          SIZE_IN_KB     = 8,
   parameter int                          READ_LATENCY   = 1,
   parameter int                          WRITE_MODE     = READ_FIRST,
   parameter int                          SCRUB_ON_RESET = 1,
   parameter logic [WORD_SIZE_BYTE*8-1:0] INIT_VALUE     = '0,
   localparam int DW    = WORD_SIZE_BYTE * 8,
   localparam int DEPTH = mem_depth(SIZE_IN_KB, WORD_SIZE_BYTE),
   localparam int AW    = mem_addr_width(DEPTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   output logic                      init_done_o,
   input  logic                      a_req_i,
   input  logic [WORD_SIZE_BYTE-1:0] a_we_i,
   input  logic [AW-1:0]             a_addr_i,
   input  logic [DW-1:0]             a_wdata_i,
   output logic                      a_gnt_o,
   output logic                      a_rvalid_o,
   output logic [DW-1:0]             a_rdata_o,
   output logic                      a_err_o,
   input  logic                      b_req_i,
   input  logic [AW-1:0]             b_addr_i,
   output logic                      b_gnt_o,
   output logic                      b_rvalid_o,
   output logic [DW-1:0]             b_rdata_o,
   output logic                      b_err_o
);

   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("memory_model_dp: READ_LATENCY must be in 1..3");
   end

   localparam logic [AW-2:0] LAST_IDX = (AW-1)'(DEPTH - 1);

   logic [DW-1:0]  mem [DEPTH];
   scrub_state_e   state_q;
   logic [AW-2:0]  scrub_cnt_q;

   logic           a_oor, b_oor, a_wr, a_rd, b_rd, b_collide;
   logic [AW-2:0]  a_idx, b_idx;
   logic [DW-1:0]  a_old, b_old, b_merged, a_rd_dat, b_rd_dat;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= (SCRUB_ON_RESET != 0) ? SCRUB : READY;
         scrub_cnt_q <= '0;
         init_done_o <= 1'b0;
      end else begin
         case (state_q)
            SCRUB: begin
               if (scrub_cnt_q == LAST_IDX) begin
                  scrub_cnt_q <= '0;
                  state_q     <= READY;
                  init_done_o <= 1'b1;
               end else begin
                  scrub_cnt_q <= scrub_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q     <= READY;
               init_done_o <= 1'b1;
            end
         endcase
      end
   end

   assign a_gnt_o = init_done_o & a_req_i;
   assign b_gnt_o = init_done_o & b_req_i;

   assign a_oor = (a_addr_i >= AW'(DEPTH));
   assign b_oor = (b_addr_i >= AW'(DEPTH));
   assign a_idx = a_addr_i[AW-2:0];
   assign b_idx = b_addr_i[AW-2:0];
   assign a_old = mem[a_idx];
   assign b_old = mem[b_idx];

   assign a_wr = a_gnt_o & (|a_we_i) & ~a_oor;
   assign a_rd = a_gnt_o & ~(|a_we_i);
   assign b_rd = b_gnt_o;

   // Word B would see if A's write landed first: new lanes where enabled, old elsewhere.
   always_comb begin
      b_merged = b_old;
      for (int i = 0; i < WORD_SIZE_BYTE; i++) begin
         if (a_we_i[i]) begin
            b_merged[i*8 +: 8] = a_wdata_i[i*8 +: 8];
         end
      end
   end

   assign b_collide = (WRITE_MODE == WRITE_FIRST) && a_wr && (a_addr_i == b_addr_i);
   assign a_rd_dat  = a_oor ? '0 : a_old;
   assign b_rd_dat  = b_oor ? '0 : (b_collide ? b_merged : b_old);

   always_ff @(posedge clk_i) begin
      if (state_q == SCRUB) begin
         mem[scrub_cnt_q] <= INIT_VALUE;
      end else if (a_wr) begin
         for (int i = 0; i < WORD_SIZE_BYTE; i++) begin
            if (a_we_i[i]) begin
               mem[a_idx][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
            end
         end
      end
   end

   mem_rd_pipe #(.LATENCY(READ_LATENCY), .DW(DW)) u_a_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .in_vld  (a_rd),
      .in_err  (a_oor),
      .in_dat  (a_rd_dat),
      .out_vld (a_rvalid_o),
      .out_err (a_err_o),
      .out_dat (a_rdata_o)
   );

   mem_rd_pipe #(.LATENCY(READ_LATENCY), .DW(DW)) u_b_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .in_vld  (b_rd),
      .in_err  (b_oor),
      .in_dat  (b_rd_dat),
      .out_vld (b_rvalid_o),
      .out_err (b_err_o),
      .out_dat (b_rdata_o)
   );

   a_no_gnt_before_init: assert property (@(posedge clk_i) disable iff (rst_i)
      !init_done_o |-> !(a_gnt_o || b_gnt_o));
   a_err_needs_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      a_err_o |-> a_rvalid_o);
   b_err_needs_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      b_err_o |-> b_rvalid_o);

endmodule

// File: tb/tb_memory_model_dp.sv
// Directed bench: p0 = read-first, latency 2, zero scrub; p1 = write-first, latency 3, patterned scrub.
module tb_memory_model_dp;

   localparam int DW = 32;
   localparam int AW = 9;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic          p0_init_done, p0_a_req, p0_a_gnt, p0_a_rvalid, p0_a_err;
   logic          p0_b_req, p0_b_gnt, p0_b_rvalid, p0_b_err;
   logic [3:0]    p0_a_we;
   logic [AW-1:0] p0_a_addr, p0_b_addr;
   logic [DW-1:0] p0_a_wdata, p0_a_rdata, p0_b_rdata;

   logic          p1_init_done, p1_a_req, p1_a_gnt, p1_a_rvalid, p1_a_err;
   logic          p1_b_req, p1_b_gnt, p1_b_rvalid, p1_b_err;
   logic [3:0]    p1_a_we;
   logic [AW-1:0] p1_a_addr, p1_b_addr;
   logic [DW-1:0] p1_a_wdata, p1_a_rdata, p1_b_rdata;

   memory_model_dp #(
      .WORD_SIZE_BYTE(4), .SIZE_IN_KB(1), .READ_LATENCY(2), .WRITE_MODE(0),
      .SCRUB_ON_RESET(1), .INIT_VALUE(32'h0000_0000)
   ) u_p0 (
      .clk_i(clk_i), .rst_i(rst_i), .init_done_o(p0_init_done),
      .a_req_i(p0_a_req), .a_we_i(p0_a_we), .a_addr_i(p0_a_addr), .a_wdata_i(p0_a_wdata),
      .a_gnt_o(p0_a_gnt), .a_rvalid_o(p0_a_rvalid), .a_rdata_o(p0_a_rdata), .a_err_o(p0_a_err),
      .b_req_i(p0_b_req), .b_addr_i(p0_b_addr), .b_gnt_o(p0_b_gnt),
      .b_rvalid_o(p0_b_rvalid), .b_rdata_o(p0_b_rdata), .b_err_o(p0_b_err)
   );

   memory_model_dp #(
      .WORD_SIZE_BYTE(4), .SIZE_IN_KB(1), .READ_LATENCY(3), .WRITE_MODE(1),
      .SCRUB_ON_RESET(1), .INIT_VALUE(32'h5A5A_0F0F)
   ) u_p1 (
      .clk_i(clk_i), .rst_i(rst_i), .init_done_o(p1_init_done),
      .a_req_i(p1_a_req), .a_we_i(p1_a_we), .a_addr_i(p1_a_addr), .a_wdata_i(p1_a_wdata),
      .a_gnt_o(p1_a_gnt), .a_rvalid_o(p1_a_rvalid), .a_rdata_o(p1_a_rdata), .a_err_o(p1_a_err),
      .b_req_i(p1_b_req), .b_addr_i(p1_b_addr), .b_gnt_o(p1_b_gnt),
      .b_rvalid_o(p1_b_rvalid), .b_rdata_o(p1_b_rdata), .b_err_o(p1_b_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle();
      p0_a_req = 1'b0; p0_a_we = '0; p0_a_addr = '0; p0_a_wdata = '0;
      p0_b_req = 1'b0; p0_b_addr = '0;
      p1_a_req = 1'b0; p1_a_we = '0; p1_a_addr = '0; p1_a_wdata = '0;
      p1_b_req = 1'b0; p1_b_addr = '0;
   endtask

   initial begin
      int   cyc;
      int   p0_cyc;
      int   p1_cyc;
      logic gnt_seen;

      // Reset state, with requests pending that must not be granted.
      idle();
      p0_a_req = 1'b1; p0_b_req = 1'b1; p1_a_req = 1'b1; p1_b_req = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk_bit("rst_init_done", p0_init_done, 1'b0);
      chk_bit("rst_a_gnt", p0_a_gnt, 1'b0);
      chk_bit("rst_b_gnt", p0_b_gnt, 1'b0);
      chk_bit("rst_a_rvalid", p0_a_rvalid, 1'b0);
      chk_bit("rst_b_err", p0_b_err, 1'b0);
      chk_word("rst_a_rdata", p0_a_rdata, 32'h0);
      chk_bit("rst_p1_init_done", p1_init_done, 1'b0);

      // Partial scrub, then reset at scrub cycle 100.
      @(negedge clk_i);
      rst_i = 1'b0;
      gnt_seen = 1'b0;
      repeat (100) begin
         @(negedge clk_i);
         #1;
         gnt_seen = gnt_seen | p0_a_gnt | p0_b_gnt | p1_a_gnt | p1_b_gnt;
      end
      rst_i = 1'b1;
      #1;
      chk_bit("midscrub_init_done", p0_init_done, 1'b0);
      chk_bit("midscrub_no_gnt", gnt_seen, 1'b0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      // Full scrub must take exactly DEPTH cycles from release.
      cyc = 0; p0_cyc = 0; p1_cyc = 0; gnt_seen = 1'b0;
      while (!(p0_init_done && p1_init_done) && cyc < 1000) begin
         @(negedge clk_i);
         #1;
         cyc++;
         if (!p0_init_done) gnt_seen = gnt_seen | p0_a_gnt | p0_b_gnt;
         if (!p1_init_done) gnt_seen = gnt_seen | p1_a_gnt | p1_b_gnt;
         if (p0_init_done && p0_cyc == 0) p0_cyc = cyc;
         if (p1_init_done && p1_cyc == 0) p1_cyc = cyc;
      end
      idle();
      chk_word("scrub_cycles_p0", p0_cyc, 32'd256);
      chk_word("scrub_cycles_p1", p1_cyc, 32'd256);
      chk_bit("scrub_no_gnt", gnt_seen, 1'b0);

      // Scrubbed contents via B.
      @(negedge clk_i);
      p0_b_req = 1'b1; p0_b_addr = 9'd0; p1_b_req = 1'b1; p1_b_addr = 9'd255;
      #1;
      chk_bit("ready_b_gnt", p0_b_gnt, 1'b1);
      @(negedge clk_i);
      p0_b_addr = 9'd255; p1_b_req = 1'b0;
      @(negedge clk_i);
      p0_b_req = 1'b0;
      #1;
      chk_bit("scrub_rd0_vld", p0_b_rvalid, 1'b1);
      chk_word("scrub_rd0_dat", p0_b_rdata, 32'h0);
      @(negedge clk_i);
      #1;
      chk_bit("scrub_rd255_vld", p0_b_rvalid, 1'b1);
      chk_word("scrub_rd255_dat", p0_b_rdata, 32'h0);
      chk_bit("p1_scrub_vld", p1_b_rvalid, 1'b1);
      chk_word("p1_scrub_dat", p1_b_rdata, 32'h5A5A_0F0F);
      @(negedge clk_i);
      #1;
      chk_bit("scrub_rd_done", p0_b_rvalid, 1'b0);

      // Byte-lane writes then read back, latency 2.
      @(negedge clk_i);
      p0_a_req = 1'b1; p0_a_we = 4'b1111; p0_a_addr = 9'd5; p0_a_wdata = 32'hAABB_CCDD;
      #1;
      chk_bit("wr_gnt", p0_a_gnt, 1'b1);
      @(negedge clk_i);
      p0_a_we = 4'b0101; p0_a_wdata = 32'h1122_3344;
      @(negedge clk_i);
      p0_a_we = 4'b0000;
      @(negedge clk_i);
      p0_a_req = 1'b0;
      #1;
      chk_bit("wr_no_rvalid", p0_a_rvalid, 1'b0);
      @(negedge clk_i);
      #1;
      chk_bit("lane_rd_vld", p0_a_rvalid, 1'b1);
      chk_word("lane_rd_dat", p0_a_rdata, 32'hAA22_CC44);
      chk_bit("lane_rd_err", p0_a_err, 1'b0);
      @(negedge clk_i);
      #1;
      chk_bit("lane_rd_vld_drop", p0_a_rvalid, 1'b0);
      chk_word("lane_rd_hold", p0_a_rdata, 32'hAA22_CC44);

      // Collisions on address 7: p0 read-first, p1 write-first with partial lanes.
      @(negedge clk_i);
      p0_a_req = 1'b1; p0_a_we = 4'b1111; p0_a_addr = 9'd7; p0_a_wdata = 32'hFFFF_FFFF;
      p0_b_req = 1'b1; p0_b_addr = 9'd7;
      p1_a_req = 1'b1; p1_a_we = 4'b0011; p1_a_addr = 9'd7; p1_a_wdata = 32'h1234_5678;
      p1_b_req = 1'b1; p1_b_addr = 9'd7;
      @(negedge clk_i);
      idle();
      @(negedge clk_i);
      #1;
      chk_bit("coll_rf_vld", p0_b_rvalid, 1'b1);
      chk_word("coll_rf_dat", p0_b_rdata, 32'h0);
      @(negedge clk_i);
      #1;
      chk_bit("coll_wf_vld", p1_b_rvalid, 1'b1);
      chk_word("coll_wf_dat", p1_b_rdata, 32'h5A5A_5678);
      p0_b_req = 1'b1; p0_b_addr = 9'd7;
      @(negedge clk_i);
      idle();
      @(negedge clk_i);
      #1;
      chk_word("coll_rf_after", p0_b_rdata, 32'hFFFF_FFFF);

      // Out-of-range accesses.
      @(negedge clk_i);
      p0_a_req = 1'b1; p0_a_we = 4'b0000; p0_a_addr = 9'd256;
      p1_b_req = 1'b1; p1_b_addr = 9'd400;
      @(negedge clk_i);
      p0_a_we = 4'b1111; p0_a_addr = 9'd300; p0_a_wdata = 32'hDEAD_BEEF;
      p1_b_req = 1'b0;
      @(negedge clk_i);
      p0_a_we = 4'b0000; p0_a_addr = 9'd44;
      #1;
      chk_bit("oor_rd_vld", p0_a_rvalid, 1'b1);
      chk_bit("oor_rd_err", p0_a_err, 1'b1);
      chk_word("oor_rd_dat", p0_a_rdata, 32'h0);
      @(negedge clk_i);
      p0_a_req = 1'b0;
      #1;
      chk_bit("oor_wr_no_rsp", p0_a_rvalid, 1'b0);
      chk_bit("oor_wr_no_err", p0_a_err, 1'b0);
      chk_bit("oor_b_vld", p1_b_rvalid, 1'b1);
      chk_bit("oor_b_err", p1_b_err, 1'b1);
      chk_word("oor_b_dat", p1_b_rdata, 32'h0);
      @(negedge clk_i);
      #1;
      chk_bit("alias44_vld", p0_a_rvalid, 1'b1);
      chk_bit("alias44_err", p0_a_err, 1'b0);
      chk_word("alias44_dat", p0_a_rdata, 32'h0);

      // Fill p1 addresses 0..15 with distinct words, then stream them out on B.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         p1_a_req = 1'b1; p1_a_we = 4'b1111; p1_a_addr = AW'(i);
         p1_a_wdata = 32'hC0DE_0000 + 32'(i);
      end
      @(negedge clk_i);
      idle();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_i);
         if (k < 16) begin
            p1_b_req = 1'b1; p1_b_addr = AW'(k);
         end else begin
            p1_b_req = 1'b0;
         end
         #1;
         if (k < 16) chk_bit("stream_gnt", p1_b_gnt, 1'b1);
         chk_bit("stream_vld", p1_b_rvalid, (k >= 3 && k < 19));
         if (k >= 3 && k < 19) chk_word("stream_dat", p1_b_rdata, 32'hC0DE_0000 + 32'(k - 3));
      end

      // Asynchronous reset while ready drops init_done without a clock edge.
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk_bit("async_rst_p0", p0_init_done, 1'b0);
      chk_bit("async_rst_p1", p1_init_done, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
